v4_peak_detector: RTL and testbench
===================================

# v4_peak_detector

Downstream stage of the v4 trapezoidal shaping filter: consumes the signed shaped stream, detects each pulse with a threshold crossing, and reports its peak amplitude, peak timestamp and width as a single record. Results are held in an output register under a valid/ready handshake toward the readout logic; a post-pulse hold-off and a rearm rule suppress retriggering on the tail of the same pulse.

## Interface
Parameters:
- SIZE_FILTER_DATA, 16, width of the signed filter sample (package value)
- TS_W, 32, timestamp counter width
- MAX_WIN, 64, maximum pulse length in valid samples before forced emission
- HOLDOFF, 16, valid samples ignored after each emission (0 allowed)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_data  in  SIZE_FILTER_DATA  signed shaped sample from the filter
- in_valid  in  1  in_data qualifier; all counting is in valid samples
- threshold  in  SIZE_FILTER_DATA  signed trigger level
- peak_valid  out  1  record available
- peak_ready  in  1  consumer accepts record when peak_valid & peak_ready
- peak_amp  out  SIZE_FILTER_DATA  signed maximum sample of the pulse
- peak_time  out  TS_W  timestamp of that maximum
- peak_width  out  $clog2(MAX_WIN+1)  valid samples above threshold
- peak_sat  out  1  pulse terminated by MAX_WIN
- drop_count  out  8  saturating count of records lost to a full output register

## Operation
- Timestamp ts: TS_W-bit counter, +1 per valid sample, wraps to 0; the sample at ts=N is the (N+1)th valid sample since reset.
- armed flag: cleared by reset and on every emission; set by any valid sample with in_data <= threshold while in IDLE.
- All comparisons signed, full SIZE_FILTER_DATA width.
- States:
  - IDLE: valid sample with armed=1 and in_data > threshold -> PULSE; latch thr_q=threshold, max=in_data, max_ts=ts, width=1.
  - PULSE (threshold changes ignored; thr_q used): valid sample > thr_q -> width+1, update max/max_ts only if in_data > max strictly (earliest maximum kept). Valid sample <= thr_q -> emit (sat=0). Width reaching MAX_WIN -> emit with sat=1 on that same sample (the sample is included).
  - Emit: -> HOLD with counter=HOLDOFF, or IDLE directly if HOLDOFF=0.
  - HOLD: each valid sample decrements; at 0 -> IDLE (unarmed).
- Output register: loaded on emit if empty or being accepted that cycle (peak_valid & peak_ready); otherwise record discarded, drop_count +1 (saturates at 255), register unchanged.
- peak_* fields stable while peak_valid=1 and not accepted.

## Timing
- Reset: state IDLE, armed=0, ts=0, peak_valid=0, peak_amp=0, peak_time=0, peak_width=0, peak_sat=0, drop_count=0. Reset mid-pulse discards the pulse and any pending record.
- Latency: peak_valid rises the cycle after the clock edge that samples the terminating sample.
- peak_valid falls the cycle after acceptance unless a new emit loads simultaneously (then stays 1 with new fields).
- in_valid=0: no state, ts, width or hold-off change.
- Throughput: one sample per clock; back-to-back records possible only with HOLDOFF=0 and an intervening below-threshold sample.
- ts wrap during a pulse: peak_time is the raw wrapped value.

## Configuration
- V4_PEAK_DROP_CNT_EN defined: drop_count implemented as above.
- Not defined: counter logic omitted, drop_count tied to 0; discard behaviour unchanged.

## Test plan
- Reset, threshold=100, samples 0,50,200,350,300,80 (valid every cycle) -> one record amp=350, time=3, width=3, sat=0; peak_valid high cycle after sample 80.
- Samples 0 then 150 ×70, threshold=100 -> record amp=150, time=1, width=64, sat=1; no new trigger until a sample <=100 seen after hold-off.
- Two pulses 20 samples apart, HOLDOFF=16, peak_ready=0 throughout -> first record held unchanged, second dropped, drop_count=1 (0 with macro undefined).
- Equal maxima 300 at ts 5 and 7 -> peak_time=5; in_valid toggling 1/0 -> same amp/time/width as continuous stream.
- Assert reset during PULSE, then feed a sample above threshold -> no record; trigger only after a sample <= threshold.
- threshold changed 100->400 mid-pulse -> termination still at first sample <=100.

Source files
------------

// File: rtl/v4_peak_detector.sv
// v4_peak_detector: threshold-triggered pulse detector on the shaped stream.
// Reports peak amplitude, peak timestamp and width per pulse via valid/ready.
// Ports: clk, reset (sync, active-high), in_data/in_valid (signed samples),
//   threshold (signed), peak_valid/peak_ready (record handshake),
//   peak_amp, peak_time, peak_width, peak_sat, drop_count.
// Optional: define V4_PEAK_DROP_CNT_EN to implement drop_count (else tied 0).
module v4_peak_detector #(
  parameter int SIZE_FILTER_DATA = 16,
  parameter int TS_W             = 32,
  parameter int MAX_WIN          = 64,
  parameter int HOLDOFF          = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic signed [SIZE_FILTER_DATA-1:0] in_data,
  input  logic                               in_valid,
  input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
  output logic                               peak_valid,
  input  logic                               peak_ready,
  output logic signed [SIZE_FILTER_DATA-1:0] peak_amp,
  output logic [TS_W-1:0]                    peak_time,
  output logic [$clog2(MAX_WIN+1)-1:0]       peak_width,
  output logic                               peak_sat,
  output logic [7:0]                         drop_count
);

  localparam int WW = $clog2(MAX_WIN+1);
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF+1) : 1;
  localparam logic [WW-1:0] WMAX = WW'(MAX_WIN);
  localparam logic [HW-1:0] HLOAD = HW'(HOLDOFF);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]                         state;
  logic                               armed;
  logic [TS_W-1:0]                    ts;
  logic [TS_W-1:0]                    max_ts;
  logic signed [SIZE_FILTER_DATA-1:0] thr_q;
  logic signed [SIZE_FILTER_DATA-1:0] max_v;
  logic [WW-1:0]                      width;
  logic [HW-1:0]                      hcnt;

  logic                               above_thr;
  logic                               above_q;
  logic                               above_max;
  logic [WW-1:0]                      width_inc;
  logic                               emit;
  logic                               load;
  logic signed [SIZE_FILTER_DATA-1:0] rec_amp;
  logic [TS_W-1:0]                    rec_ts;
  logic [WW-1:0]                      rec_width;

  assign above_thr = in_data > threshold;
  assign above_q   = in_data > thr_q;
  assign above_max = in_data > max_v;
  assign width_inc = width + WW'(1);

  // A pulse ends on the first sample at/below the latched level, or when
  // an above-level sample brings the width to MAX_WIN (sample included).
  assign emit = in_valid && (state == S_PULSE)
              && (!above_q || (width_inc == WMAX));

  // Strict compare keeps the earliest of equal maxima.
  assign rec_amp   = (above_q && above_max) ? in_data : max_v;
  assign rec_ts    = (above_q && above_max) ? ts : max_ts;
  assign rec_width = above_q ? width_inc : width;

  // The output register can take a record if empty or drained this cycle.
  assign load = emit && (!peak_valid || peak_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      armed      <= 1'b0;
      ts         <= '0;
      max_ts     <= '0;
      thr_q      <= '0;
      max_v      <= '0;
      width      <= '0;
      hcnt       <= '0;
      peak_valid <= 1'b0;
      peak_amp   <= '0;
      peak_time  <= '0;
      peak_width <= '0;
      peak_sat   <= 1'b0;
    end else begin
      if (in_valid) begin
        ts <= ts + TS_W'(1);
        case (state)
          S_IDLE: begin
            if (!above_thr) begin
              armed <= 1'b1;
            end else if (armed) begin
              state  <= S_PULSE;
              thr_q  <= threshold;
              max_v  <= in_data;
              max_ts <= ts;
              width  <= WW'(1);
            end
          end
          S_PULSE: begin
            if (emit) begin
              armed <= 1'b0;
              hcnt  <= HLOAD;
              state <= (HOLDOFF == 0) ? S_IDLE : S_HOLD;
            end else begin
              width <= width_inc;
              if (above_max) begin
                max_v  <= in_data;
                max_ts <= ts;
              end
            end
          end
          S_HOLD: begin
            hcnt <= hcnt - HW'(1);
            if (hcnt == HW'(1)) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end

      if (load) begin
        peak_valid <= 1'b1;
        peak_amp   <= rec_amp;
        peak_time  <= rec_ts;
        peak_width <= rec_width;
        peak_sat   <= above_q;
      end else if (peak_valid && peak_ready) begin
        peak_valid <= 1'b0;
      end
    end
  end

`ifdef V4_PEAK_DROP_CNT_EN
  logic [7:0] drop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
    end else if (emit && !load && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_v4_peak_detector.sv
// tb_v4_peak_detector: directed plus randomized check of v4_peak_detector
// against a queue-based pulse model.
module tb_v4_peak_detector;

  localparam int D       = 16;
  localparam int TS_W    = 32;
  localparam int MAX_WIN = 64;
  localparam int HOLDOFF = 16;
  localparam int WW      = $clog2(MAX_WIN+1);

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic signed [D-1:0] in_data = '0;
  logic                in_valid = 1'b0;
  logic signed [D-1:0] threshold = 16'sd100;
  logic                peak_valid;
  logic                peak_ready = 1'b0;
  logic signed [D-1:0] peak_amp;
  logic [TS_W-1:0]     peak_time;
  logic [WW-1:0]       peak_width;
  logic                peak_sat;
  logic [7:0]          drop_count;

  int total = 0;
  int bad = 0;
  bit go = 1'b0;

  always #5 clk = ~clk;

  v4_peak_detector #(
    .SIZE_FILTER_DATA(D),
    .TS_W(TS_W),
    .MAX_WIN(MAX_WIN),
    .HOLDOFF(HOLDOFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .threshold(threshold),
    .peak_valid(peak_valid),
    .peak_ready(peak_ready),
    .peak_amp(peak_amp),
    .peak_time(peak_time),
    .peak_width(peak_width),
    .peak_sat(peak_sat),
    .drop_count(drop_count)
  );

  // Reference model: collect the samples of a pulse, reduce at the end.
  int              qv[$];
  logic [TS_W-1:0] qt[$];
  logic [TS_W-1:0] m_ts;
  bit              m_armed, m_in;
  int              m_thr, m_hold;
  bit              e_valid, e_sat;
  int              e_amp, e_width, e_drop;
  logic [TS_W-1:0] e_time;
  bit              m_emit, m_esat;
  int              m_d, m_amp;
  logic [TS_W-1:0] m_tim;

  always @(posedge clk) begin
    if (reset) begin
      m_ts = '0; m_armed = 0; m_in = 0; m_hold = 0;
      qv.delete(); qt.delete();
      e_valid = 0; e_amp = 0; e_time = '0; e_width = 0;
      e_sat = 0; e_drop = 0;
    end else begin
      m_emit = 0; m_esat = 0;
      if (in_valid) begin
        m_d = int'(in_data);
        if (m_hold > 0) begin
          m_hold--;
        end else if (m_in) begin
          if (m_d > m_thr) begin
            qv.push_back(m_d); qt.push_back(m_ts);
            if (qv.size() == MAX_WIN) begin
              m_emit = 1; m_esat = 1;
            end
          end else begin
            m_emit = 1;
          end
        end else if (m_d <= int'(threshold)) begin
          m_armed = 1;
        end else if (m_armed) begin
          m_in = 1; m_thr = int'(threshold);
          qv.push_back(m_d); qt.push_back(m_ts);
        end
        m_ts++;
      end
      if (m_emit) begin
        m_amp = qv[0]; m_tim = qt[0];
        foreach (qv[i]) if (qv[i] > m_amp) begin
          m_amp = qv[i]; m_tim = qt[i];
        end
        if (!e_valid || peak_ready) begin
          e_valid = 1; e_amp = m_amp; e_time = m_tim;
          e_width = qv.size(); e_sat = m_esat;
        end else begin
`ifdef V4_PEAK_DROP_CNT_EN
          if (e_drop < 255) e_drop++;
`endif
        end
        qv.delete(); qt.delete();
        m_in = 0; m_armed = 0; m_hold = HOLDOFF;
      end else if (e_valid && peak_ready) begin
        e_valid = 0;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (go) begin
      chk("valid", longint'(peak_valid), longint'(e_valid));
      chk("amp", longint'(peak_amp), longint'(e_amp));
      chk("time", longint'(peak_time), longint'(e_time));
      chk("width", longint'(peak_width), longint'(e_width));
      chk("sat", longint'(peak_sat), longint'(e_sat));
      chk("drop", longint'(drop_count), longint'(e_drop));
    end
  end

  task automatic drive(input bit v, input int d);
    in_valid = v;
    in_data = 16'(d);
    @(negedge clk);
  endtask

  task automatic rst();
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic rec(input string nm, input int a, input int t,
                     input int w, input int s);
    chk({nm, "_v"}, longint'(peak_valid), 1);
    chk({nm, "_amp"}, longint'(peak_amp), a);
    chk({nm, "_time"}, longint'(peak_time), t);
    chk({nm, "_width"}, longint'(peak_width), w);
    chk({nm, "_sat"}, longint'(peak_sat), s);
  endtask

  int seq4[9] = '{0, 0, 0, 150, 200, 300, 250, 300, 0};
  int seq1[6] = '{0, 50, 200, 350, 300, 80};
  int mode, d;
  bit v;

  initial begin
    @(negedge clk);
    rst();
    go = 1'b1;
    chk("rst_valid", longint'(peak_valid), 0);
    chk("rst_amp", longint'(peak_amp), 0);
    chk("rst_drop", longint'(drop_count), 0);

    // basic pulse
    threshold = 16'sd100;
    foreach (seq1[i]) begin
      drive(1, seq1[i]);
      if (i == 4) chk("t1_early", longint'(peak_valid), 0);
    end
    rec("t1", 350, 3, 3, 0);
    peak_ready = 1'b1;
    drive(1, 0);
    peak_ready = 1'b0;
    chk("t1_fall", longint'(peak_valid), 0);

    // forced emission at MAX_WIN, no retrigger without rearm
    rst();
    drive(1, 0);
    repeat (70) drive(1, 150);
    rec("t2", 150, 1, 64, 1);
    repeat (20) drive(1, 150);
    rec("t2_hold", 150, 1, 64, 1);
    drive(1, 100);
    peak_ready = 1'b1;
    drive(1, 150);
    peak_ready = 1'b0;
    drive(1, 150);
    drive(1, 150);
    drive(1, 0);
    rec("t2_next", 150, 92, 3, 0);

    // second record dropped while the first is held
    rst();
    drive(1, 0); drive(1, 200); drive(1, 0);
    repeat (16) drive(1, 0);
    drive(1, 0); drive(1, 300); drive(1, 0);
    rec("t3", 200, 1, 1, 0);
`ifdef V4_PEAK_DROP_CNT_EN
    chk("t3_drop", longint'(drop_count), 1);
`else
    chk("t3_drop", longint'(drop_count), 0);
`endif

    // equal maxima, continuous then gapped
    rst();
    foreach (seq4[i]) drive(1, seq4[i]);
    rec("t4", 300, 5, 5, 0);
    rst();
    foreach (seq4[i]) begin
      drive(1, seq4[i]);
      drive(0, 999);
    end
    rec("t4_gap", 300, 5, 5, 0);

    // reset mid-pulse
    rst();
    drive(1, 0); drive(1, 200); drive(1, 250);
    rst();
    drive(1, 300);
    chk("t5_none", longint'(peak_valid), 0);
    drive(1, 0);
    chk("t5_none2", longint'(peak_valid), 0);
    drive(1, 300); drive(1, 0);
    rec("t5", 300, 2, 1, 0);

    // threshold change mid-pulse ignored
    rst();
    drive(1, 0); drive(1, 200);
    threshold = 16'sd400;
    drive(1, 300); drive(1, 150);
    chk("t6_open", longint'(peak_valid), 0);
    drive(1, 50);
    rec("t6", 300, 2, 3, 0);
    threshold = 16'sd100;

    // randomized
    rst();
    for (int i = 0; i < 4000; i++) begin
      mode = (i / 250) % 4;
      if (i % 97 == 0) threshold = 16'($urandom_range(50, 200));
      reset = ($urandom_range(0, 999) == 0);
      if (mode == 3) peak_ready = ($urandom_range(0, 9) == 0);
      else peak_ready = $urandom_range(0, 1) == 1;
      v = ($urandom_range(0, 3) != 0);
      case (mode)
        1: d = ($urandom_range(0, 9) != 0) ?
               150 + int'($urandom_range(0, 350)) :
               int'($urandom_range(0, 100)) - 50;
        2: d = (((i / 8) % 2) == 1) ?
               int'($urandom_range(150, 600)) :
               int'($urandom_range(0, 300)) - 200;
        default: d = int'($urandom_range(0, 800)) - 300;
      endcase
      drive(v, d);
    end
    reset = 1'b0;
    drive(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
